// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the register-file write arbiter slice.
package rf_arb_pkg;

    localparam int unsigned DEFAULT_WIDTH      = 32;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 5;
    localparam int unsigned DEFAULT_NUM        = 32;
    localparam int unsigned CNT_W              = 4;

    localparam logic [DEFAULT_ADDR_WIDTH-1:0] REG_ZERO = '0;

    typedef enum logic {
        WB_PRI    = 1'b0,
        ASYNC_PRI = 1'b1
    } arb_mode_e;

endpackage

// File: rtl/rf_pending_table.sv
// Outstanding long-latency destination bitmap with protocol-error tracking
// and the ID-stage read-hazard compare.
module rf_pending_table
    import rf_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned NUM        = DEFAULT_NUM
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_issue,
    input  logic [ADDR_WIDTH-1:0] i_issue_addr,
    input  logic                  i_grant,
    input  logic [ADDR_WIDTH-1:0] i_grant_addr,
    input  logic                  i_wb_we,
    input  logic [ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [ADDR_WIDTH-1:0] i_rs_addr,
    input  logic [ADDR_WIDTH-1:0] i_rt_addr,
    output logic [NUM-1:0]        o_pending,
    output logic                  o_pend_err,
    output logic                  o_hazard_stall
);

    logic [NUM-1:0] r_pending;
    logic           r_pend_err;
    logic [NUM-1:0] w_set_mask;
    logic [NUM-1:0] w_clr_mask;
    logic           w_issue_nz;
    logic           w_grant_nz;
    logic           w_err;
    logic           w_rs_haz;
    logic           w_rt_haz;

    assign w_issue_nz = i_issue && (i_issue_addr != ADDR_WIDTH'(REG_ZERO));
    assign w_grant_nz = i_grant && (i_grant_addr != ADDR_WIDTH'(REG_ZERO));

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (w_issue_nz) w_set_mask = NUM'(1) << i_issue_addr;
        if (w_grant_nz) w_clr_mask = NUM'(1) << i_grant_addr;
    end

    // Re-issue is only legal when the same address retires in this cycle.
    always_comb begin
        w_err = 1'b0;
        if (w_issue_nz && r_pending[i_issue_addr] &&
            !(i_grant && (i_grant_addr == i_issue_addr)))
            w_err = 1'b1;
        if (w_grant_nz && !r_pending[i_grant_addr])
            w_err = 1'b1;
        if (i_wb_we && r_pending[i_wb_addr])
            w_err = 1'b1;
    end

    // Set wins over clear on the same address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_pend_err <= 1'b0;
        end else begin
            r_pending  <= (r_pending & ~w_clr_mask) | w_set_mask;
            r_pend_err <= r_pend_err | w_err;
        end
    end

    // A grant in this cycle is bypassed by the register file, so no stall.
    assign w_rs_haz = r_pending[i_rs_addr] && (i_rs_addr != ADDR_WIDTH'(REG_ZERO)) &&
                      !(i_grant && (i_grant_addr == i_rs_addr));
    assign w_rt_haz = r_pending[i_rt_addr] && (i_rt_addr != ADDR_WIDTH'(REG_ZERO)) &&
                      !(i_grant && (i_grant_addr == i_rt_addr));

    assign o_pending      = r_pending;
    assign o_pend_err     = r_pend_err;
    assign o_hazard_stall = w_rs_haz || w_rt_haz;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register-file write port between WB and the long-latency
// result source, with a starvation guard that forces one async grant.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned WIDTH        = DEFAULT_WIDTH,
    parameter int unsigned ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int unsigned NUM          = DEFAULT_NUM,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wb_we,
    input  logic [ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [WIDTH-1:0]      i_wb_data,
    output logic                  o_wb_hold,
    input  logic                  i_async_issue,
    input  logic [ADDR_WIDTH-1:0] i_async_issue_addr,
    input  logic                  i_async_valid,
    input  logic [ADDR_WIDTH-1:0] i_async_addr,
    input  logic [WIDTH-1:0]      i_async_data,
    output logic                  o_async_ready,
    output logic                  o_rf_we,
    output logic [ADDR_WIDTH-1:0] o_rf_waddr,
    output logic [WIDTH-1:0]      o_rf_wdata,
    input  logic [ADDR_WIDTH-1:0] i_rs_addr,
    input  logic [ADDR_WIDTH-1:0] i_rt_addr,
    output logic                  o_hazard_stall,
    output logic [NUM-1:0]        o_pending,
    output logic                  o_pend_err
);

    arb_mode_e        r_mode;
    arb_mode_e        w_mode_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_wb_win;
    logic             w_async_win;
    logic             w_blocked;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= WB_PRI;
            r_cnt  <= '0;
        end else begin
            r_mode <= w_mode_next;
            r_cnt  <= w_cnt_next;
        end
    end

    assign w_blocked = i_async_valid && !w_async_win;

    // Next state: the mode flips on the same edge the counter reaches the limit.
    always_comb begin
        w_mode_next = r_mode;
        w_cnt_next  = w_blocked ? r_cnt + CNT_W'(1) : '0;
        case (r_mode)
            WB_PRI: begin
                if (w_blocked && (r_cnt >= CNT_W'(STARVE_LIMIT - 1)))
                    w_mode_next = ASYNC_PRI;
            end
            ASYNC_PRI: begin
                if (w_async_win || !i_async_valid)
                    w_mode_next = WB_PRI;
            end
            default: w_mode_next = WB_PRI;
        endcase
    end

    // Grant and write-port mux
    always_comb begin
        w_wb_win    = 1'b0;
        w_async_win = 1'b0;
        o_wb_hold   = 1'b0;
        o_rf_we     = 1'b0;
        o_rf_waddr  = '0;
        o_rf_wdata  = '0;
        case (r_mode)
            WB_PRI: begin
                w_wb_win    = i_wb_we;
                w_async_win = i_async_valid && !i_wb_we;
            end
            ASYNC_PRI: begin
                w_async_win = i_async_valid;
                o_wb_hold   = i_wb_we;
            end
            default: ;
        endcase
        if (w_wb_win) begin
            o_rf_waddr = i_wb_addr;
            o_rf_wdata = i_wb_data;
        end else if (w_async_win) begin
            o_rf_waddr = i_async_addr;
            o_rf_wdata = i_async_data;
        end
        o_rf_we = (w_wb_win || w_async_win) && (o_rf_waddr != ADDR_WIDTH'(REG_ZERO));
    end

    assign o_async_ready = w_async_win;

    rf_pending_table #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM        (NUM)
    ) u_pending (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_issue        (i_async_issue),
        .i_issue_addr   (i_async_issue_addr),
        .i_grant        (w_async_win),
        .i_grant_addr   (i_async_addr),
        .i_wb_we        (i_wb_we),
        .i_wb_addr      (i_wb_addr),
        .i_rs_addr      (i_rs_addr),
        .i_rt_addr      (i_rt_addr),
        .o_pending      (o_pending),
        .o_pend_err     (o_pend_err),
        .o_hazard_stall (o_hazard_stall)
    );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed scenario bench for rf_write_arbiter with hand-computed expectations.
module tb_rf_write_arbiter;

    localparam int unsigned W  = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned N  = 32;

    logic          clk;
    logic          rst_n;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [W-1:0]  wb_data;
    logic          wb_hold;
    logic          async_issue;
    logic [AW-1:0] async_issue_addr;
    logic          async_valid;
    logic [AW-1:0] async_addr;
    logic [W-1:0]  async_data;
    logic          async_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [W-1:0]  rf_wdata;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic          hazard_stall;
    logic [N-1:0]  pending;
    logic          pend_err;

    int n_tests;
    int n_fail;

    rf_write_arbiter #(
        .WIDTH        (W),
        .ADDR_WIDTH   (AW),
        .NUM          (N),
        .STARVE_LIMIT (4)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_wb_we            (wb_we),
        .i_wb_addr          (wb_addr),
        .i_wb_data          (wb_data),
        .o_wb_hold          (wb_hold),
        .i_async_issue      (async_issue),
        .i_async_issue_addr (async_issue_addr),
        .i_async_valid      (async_valid),
        .i_async_addr       (async_addr),
        .i_async_data       (async_data),
        .o_async_ready      (async_ready),
        .o_rf_we            (rf_we),
        .o_rf_waddr         (rf_waddr),
        .o_rf_wdata         (rf_wdata),
        .i_rs_addr          (rs_addr),
        .i_rt_addr          (rt_addr),
        .o_hazard_stall     (hazard_stall),
        .o_pending          (pending),
        .o_pend_err         (pend_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        wb_we = 0; wb_addr = '0; wb_data = '0;
        async_issue = 0; async_issue_addr = '0;
        async_valid = 0; async_addr = '0; async_data = '0;
        rs_addr = '0; rt_addr = '0;
    endtask

    // Move to the middle of the next cycle; inputs are driven right after.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({rf_we, rf_waddr, rf_wdata, async_ready, wb_hold, hazard_stall, pend_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got we=%0b addr=%0d data=%h rdy=%0b hold=%0b haz=%0b err=%0b exp all 0",
                     rf_we, rf_waddr, rf_wdata, async_ready, wb_hold, hazard_stall, pend_err);
        end
        n_tests++;
        if (pending !== 32'h0) begin
            n_fail++; $display("FAIL reset_pending got %h exp 00000000", pending);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_async_only();
        next_cycle(); idle(); async_issue = 1; async_issue_addr = 5'd5;
        next_cycle(); idle();
        async_valid = 1; async_addr = 5'd5; async_data = 32'hDEADBEEF;
        #1;
        n_tests++;
        if (pending !== 32'h0000_0020) begin
            n_fail++; $display("FAIL async_pend_set got %h exp 00000020", pending);
        end
        n_tests++;
        if ({rf_we, rf_waddr, rf_wdata, async_ready, wb_hold} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL async_write got we=%0b addr=%0d data=%h rdy=%0b hold=%0b exp 1/5/deadbeef/1/0",
                     rf_we, rf_waddr, rf_wdata, async_ready, wb_hold);
        end
        next_cycle(); idle(); #1;
        n_tests++;
        if ({pending, pend_err, rf_we} !== {32'h0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL async_pend_clr got pend=%h err=%0b we=%0b exp 0/0/0", pending, pend_err, rf_we);
        end
    endtask

    task automatic test_contention();
        logic exp_async;
        next_cycle(); idle(); async_issue = 1; async_issue_addr = 5'd9;
        for (int c = 1; c <= 6; c++) begin
            next_cycle(); idle();
            wb_we = 1; wb_addr = 5'd2; wb_data = 32'h1111_1111;
            async_valid = (c <= 5); async_addr = 5'd9; async_data = 32'h9999_9999;
            #1;
            exp_async = (c == 5);
            n_tests++;
            if (exp_async) begin
                if ({async_ready, wb_hold, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 1'b1, 5'd9, 32'h9999_9999}) begin
                    n_fail++;
                    $display("FAIL contention_c%0d got rdy=%0b hold=%0b we=%0b addr=%0d data=%h exp async win with hold",
                             c, async_ready, wb_hold, rf_we, rf_waddr, rf_wdata);
                end
            end else begin
                if ({async_ready, wb_hold, rf_we, rf_waddr, rf_wdata} !== {1'b0, 1'b0, 1'b1, 5'd2, 32'h1111_1111}) begin
                    n_fail++;
                    $display("FAIL contention_c%0d got rdy=%0b hold=%0b we=%0b addr=%0d data=%h exp wb win",
                             c, async_ready, wb_hold, rf_we, rf_waddr, rf_wdata);
                end
            end
        end
        next_cycle(); idle(); #1;
        n_tests++;
        if ({pending, pend_err} !== {32'h0, 1'b0}) begin
            n_fail++; $display("FAIL contention_state got pend=%h err=%0b exp 0/0", pending, pend_err);
        end
    endtask

    task automatic test_hazard();
        next_cycle(); idle();
        async_issue = 1; async_issue_addr = 5'd8; rs_addr = 5'd8; #1;
        n_tests++;
        if (hazard_stall !== 1'b0) begin
            n_fail++; $display("FAIL hazard_issue_cycle got %0b exp 0", hazard_stall);
        end
        next_cycle(); idle(); rs_addr = 5'd8; #1;
        n_tests++;
        if (hazard_stall !== 1'b1) begin
            n_fail++; $display("FAIL hazard_rs got %0b exp 1", hazard_stall);
        end
        next_cycle(); idle(); rt_addr = 5'd8; #1;
        n_tests++;
        if (hazard_stall !== 1'b1) begin
            n_fail++; $display("FAIL hazard_rt got %0b exp 1", hazard_stall);
        end
        next_cycle(); idle();
        rs_addr = 5'd8; async_valid = 1; async_addr = 5'd8; async_data = 32'h0000_0088; #1;
        n_tests++;
        if ({hazard_stall, rf_we, rf_waddr} !== {1'b0, 1'b1, 5'd8}) begin
            n_fail++; $display("FAIL hazard_grant_cycle got haz=%0b we=%0b addr=%0d exp 0/1/8", hazard_stall, rf_we, rf_waddr);
        end
        next_cycle(); idle(); rs_addr = 5'd8; #1;
        n_tests++;
        if ({hazard_stall, pending} !== {1'b0, 32'h0}) begin
            n_fail++; $display("FAIL hazard_after got haz=%0b pend=%h exp 0/0", hazard_stall, pending);
        end
    endtask

    task automatic test_addr0();
        next_cycle(); idle();
        async_valid = 1; async_addr = 5'd0; async_data = 32'h55;
        async_issue = 1; async_issue_addr = 5'd0; #1;
        n_tests++;
        if ({async_ready, rf_we} !== 2'b10) begin
            n_fail++; $display("FAIL addr0_write got rdy=%0b we=%0b exp 1/0", async_ready, rf_we);
        end
        next_cycle(); idle(); #1;
        n_tests++;
        if ({pending, pend_err, hazard_stall} !== {32'h0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL addr0_state got pend=%h err=%0b haz=%0b exp 0/0/0", pending, pend_err, hazard_stall);
        end
    endtask

    task automatic test_errors();
        next_cycle(); idle(); async_issue = 1; async_issue_addr = 5'd3;
        next_cycle(); idle();
        async_issue = 1; async_issue_addr = 5'd3;
        async_valid = 1; async_addr = 5'd3; async_data = 32'h3333; #1;
        n_tests++;
        if (async_ready !== 1'b1) begin
            n_fail++; $display("FAIL err_same_cycle_grant got rdy=%0b exp 1", async_ready);
        end
        next_cycle(); idle(); #1;
        n_tests++;
        if ({pending, pend_err} !== {32'h0000_0008, 1'b0}) begin
            n_fail++; $display("FAIL err_set_wins got pend=%h err=%0b exp 00000008/0", pending, pend_err);
        end
        async_issue = 1; async_issue_addr = 5'd3;
        next_cycle(); idle(); #1;
        n_tests++;
        if (pend_err !== 1'b1) begin
            n_fail++; $display("FAIL err_reissue got %0b exp 1", pend_err);
        end
        repeat (3) next_cycle();
        #1;
        n_tests++;
        if (pend_err !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky got %0b exp 1", pend_err);
        end
    endtask

    task automatic test_reset_mid();
        next_cycle(); rst_n = 1'b0; idle();
        next_cycle(); rst_n = 1'b1;
        next_cycle(); idle(); async_issue = 1; async_issue_addr = 5'd5;
        next_cycle(); idle(); async_issue = 1; async_issue_addr = 5'd8;
        for (int c = 1; c <= 2; c++) begin
            next_cycle(); idle();
            wb_we = 1; wb_addr = 5'd2; wb_data = 32'h2222;
            async_valid = 1; async_addr = 5'd5; async_data = 32'h5555;
        end
        #1;
        n_tests++;
        if ({pending, pend_err} !== {32'h0000_0120, 1'b0}) begin
            n_fail++; $display("FAIL rstmid_setup got pend=%h err=%0b exp 00000120/0", pending, pend_err);
        end
        // Pulse reset between clock edges so only the async path can clear state.
        next_cycle(); idle(); #2; rst_n = 1'b0; #1;
        n_tests++;
        if ({pending, pend_err, rf_we, rf_waddr, rf_wdata, async_ready, wb_hold} !== '0) begin
            n_fail++; $display("FAIL rstmid_async got pend=%h err=%0b we=%0b exp all 0", pending, pend_err, rf_we);
        end
        next_cycle(); rst_n = 1'b1;
        next_cycle(); idle(); async_issue = 1; async_issue_addr = 5'd5;
        for (int c = 1; c <= 5; c++) begin
            next_cycle(); idle();
            wb_we = 1; wb_addr = 5'd2; wb_data = 32'h2222;
            async_valid = 1; async_addr = 5'd5; async_data = 32'h5555; #1;
            n_tests++;
            if (async_ready !== (c == 5)) begin
                n_fail++; $display("FAIL rstmid_cnt_c%0d got rdy=%0b exp %0b", c, async_ready, (c == 5));
            end
        end
        next_cycle(); idle(); #1;
        n_tests++;
        if ({pending, pend_err} !== {32'h0, 1'b0}) begin
            n_fail++; $display("FAIL rstmid_final got pend=%h err=%0b exp 0/0", pending, pend_err);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_async_only();
        test_contention();
        test_hazard();
        test_addr0();
        test_errors();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single write port of the ID-stage register file between the in-order pipeline writeback (WB) and a long-latency result source (multiply/divide unit, CP0 moves). It tracks registers with outstanding long-latency writes and raises an ID-stage hazard stall on reads of them. It guarantees that the long-latency source cannot starve: after `STARVE_LIMIT` consecutive blocked cycles, the block holds WB for one cycle. It sits between the WB stage, the long-latency unit and the register file's `RegWrite`/`Write_register`/`Write_data` inputs.

## Interface
- `WIDTH`, 32, data width
- `ADDR_WIDTH`, 5, register address width
- `NUM`, 32, number of architectural registers
- `STARVE_LIMIT`, 4, consecutive blocked async cycles before a forced grant (range 1..15)

- `clk`  input  1  clock
- `rst_n`  input  1  reset, asynchronous, active-low
- `wb_we`  input  1  WB write request
- `wb_addr`  input  ADDR_WIDTH  WB destination
- `wb_data`  input  WIDTH  WB data
- `wb_hold`  output  1  WB must hold its request this cycle (not written)
- `async_issue`  input  1  ID issues a long-latency op this cycle
- `async_issue_addr`  input  ADDR_WIDTH  its destination
- `async_valid`  input  1  long-latency result available
- `async_addr`  input  ADDR_WIDTH  result destination
- `async_data`  input  WIDTH  result data
- `async_ready`  output  1  result accepted this cycle
- `rf_we`  output  1  register file write enable
- `rf_waddr`  output  ADDR_WIDTH  register file write address
- `rf_wdata`  output  WIDTH  register file write data
- `rs_addr`, `rt_addr`  input  ADDR_WIDTH each  ID read addresses
- `hazard_stall`  output  1  ID must stall
- `pending`  output  NUM  outstanding async destinations
- `pend_err`  output  1  sticky protocol error

## Operation
- Grant per cycle. One winner, combinational from inputs plus state.
  - Mode `WB_PRI`: WB wins when `wb_we`. Otherwise async wins when `async_valid`.
  - Mode `ASYNC_PRI`: async wins when `async_valid`. `wb_hold` = `wb_we`.
- `async_ready` = async wins.
- `rf_we` = winner exists and winner address != 0. An address-0 async write still completes its handshake.
- `rf_waddr`/`rf_wdata` come from the winner. When there is no winner they are 0.
- Starvation counter `cnt`:
  - Increments on each cycle with `async_valid` and no async grant.
  - Clears on an async grant or when `async_valid` is low.
- Mode FSM:
  - `WB_PRI` → `ASYNC_PRI` when `cnt` reaches `STARVE_LIMIT` (registered).
  - `ASYNC_PRI` → `WB_PRI` after exactly one async grant, or immediately if `async_valid` drops.
- Pending bitmap:
  - `async_issue` with a nonzero address sets the bit at the next edge.
  - An async grant clears the bit of `async_addr` at the next edge.
  - Set and clear on the same address in the same cycle: set wins.
- `hazard_stall` = (`pending[rs_addr]` and `rs_addr` != 0 and not (async grant to `rs_addr` this cycle)) or the same condition for `rt_addr`. This relies on the register file's same-cycle write bypass.
- `pend_err` sets, and stays set until reset, on any of:
  - `async_issue` to an already-pending address with no same-cycle clear;
  - an async grant to a non-pending nonzero address;
  - `wb_we` to a pending address.

## Timing
- Reset values: all outputs 0, `pending` = 0, `cnt` = 0, mode `WB_PRI`, `pend_err` = 0.
- Reset mid-operation discards all outstanding state immediately.
- Write path has zero latency: a request in cycle N is written at the edge ending cycle N.
- Pending bit is visible the cycle after `async_issue`. Clear takes effect at the grant edge, and `hazard_stall` is already low during the grant cycle.
- Forced grant: with `async_valid` and `wb_we` continuously high, async is granted in cycle `STARVE_LIMIT`+1 (counting from 1), with `wb_hold` high in that cycle only.
- Both sources must keep address and data stable while request is high and not granted or held.

## Structure
- Shared package `rf_arb_pkg` holds:
  - mode enum `WB_PRI`/`ASYNC_PRI`;
  - `ADDR_WIDTH`/`WIDTH` defaults;
  - the `REG_ZERO` constant.
- One natural sub-module: `rf_pending_table`. It contains the bitmap, set/clear and error logic, and the two read-compare hazard outputs. Grant logic and FSM stay in the top.

## Test plan
- Async only: `async_valid`, addr 5, data 0xDEADBEEF → `rf_we`=1, `rf_waddr`=5, `async_ready`=1 the same cycle; `pending[5]` clears at the next edge.
- Contention with `STARVE_LIMIT`=4: `wb_we` and `async_valid` held high → WB wins cycles 1–4; cycle 5 async wins with `wb_hold`=1; cycle 6 WB wins again.
- Hazard: `async_issue` addr 8, then `rs_addr`=8 → `hazard_stall`=1 from the next cycle until the grant cycle, where it is 0. `rt_addr`=0 never stalls.
- Address 0: async result to reg 0 → `async_ready`=1, `rf_we`=0. Issue to reg 0 does not set `pending`.
- Errors: second `async_issue` to pending addr 3 → `pend_err`=1, which persists. Same-cycle grant to 3 plus issue to 3 → `pending[3]` stays 1 with no error.
- Reset asserted with `pending`=0x00000120 and `cnt`=2 → all outputs and state become 0 asynchronously, and mode is `WB_PRI` after release.
